// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and datapath/memory (slave).
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       ALUSrc;
  logic       Branch;
  logic       Jump;
  logic       PCWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  Opcode, mem_ready,
    output mem_req, MemRead, MemWrite, RegWrite, ALUSrc, Branch, Jump,
           PCWrite, IRWrite, MemtoReg, ALUOp, state, illegal, timeout
  );

  modport slave (
    output Opcode, mem_ready,
    input  mem_req, MemRead, MemWrite, RegWrite, ALUSrc, Branch, Jump,
           PCWrite, IRWrite, MemtoReg, ALUOp, state, illegal, timeout
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: 3-5 cycles per instruction with zero-wait memory.
// Memory backpressure holds FETCH/MEM while mem_ready=0, trapping after TIMEOUT_CYCLES waits.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ENABLE_JAL     = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state_q;
  logic [6:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q;
  logic          timeout_q;
  logic          timeout_hit;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR: is_legal = 1'b1;
      OP_JAL:                                  is_legal = ENABLE_JAL;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  // This wait cycle would be the TIMEOUT_CYCLES-th one without a completion.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH, MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (state_q == FETCH)  state_q <= DECODE;
            else if (op_q == OP_LW) state_q <= WB;
            else                   state_q <= FETCH;
          end else if (timeout_hit) begin
            wait_cnt  <= '0;
            state_q   <= TRAP;
            timeout_q <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          op_q <= bus.Opcode;
          if (is_legal(bus.Opcode)) begin
            state_q <= EXECUTE;
          end else begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXECUTE: begin
          case (op_q)
            OP_LW, OP_SW: state_q <= MEM;
            OP_BR:        state_q <= FETCH;
            default:      state_q <= WB;
          endcase
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= TRAP;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;

  // Controls decode from state and op_q; reset forces every control low immediately.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemtoReg = 2'b00;
    bus.ALUOp    = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.mem_ready;
        end
        EXECUTE: begin
          bus.ALUSrc = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_I) ||
                       (op_q == OP_LUI) || (op_q == OP_JAL);
          case (op_q)
            OP_BR:          bus.ALUOp = 2'b01;
            OP_R, OP_I:     bus.ALUOp = 2'b10;
            OP_LUI, OP_JAL: bus.ALUOp = 2'b11;
            default:        bus.ALUOp = 2'b00;
          endcase
          bus.Jump    = (op_q == OP_JAL);
          bus.Branch  = (op_q == OP_BR);
          bus.PCWrite = (op_q == OP_BR);
        end
        MEM: begin
          bus.mem_req  = 1'b1;
          bus.MemRead  = (op_q == OP_LW);
          bus.MemWrite = (op_q == OP_SW);
          bus.PCWrite  = (op_q == OP_SW) && bus.mem_ready;
        end
        WB: begin
          bus.RegWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          if (op_q == OP_LW)       bus.MemtoReg = 2'b01;
          else if (op_q == OP_JAL) bus.MemtoReg = 2'b10;
          else                     bus.MemtoReg = 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus program/JAL-disabled sequences.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller_if nj_bus ();

  multicycle_controller #(.TIMEOUT_CYCLES(4), .ENABLE_JAL(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  multicycle_controller #(.TIMEOUT_CYCLES(16), .ENABLE_JAL(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .bus(nj_bus)
  );

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0001111;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

  // Control word: {mem_req, MemRead, MemWrite, RegWrite, ALUSrc, Branch, Jump, PCWrite, IRWrite, MemtoReg, ALUOp}
  localparam logic [12:0] MREQ = 13'h1000, MRD = 13'h0800, MWR = 13'h0400, RGW = 13'h0200;
  localparam logic [12:0] ASRC = 13'h0100, BRN = 13'h0080, JMP = 13'h0040, PCW = 13'h0020;
  localparam logic [12:0] IRW  = 13'h0010, M2R_MEM = 13'h0004, M2R_PC4 = 13'h0008;
  localparam logic [12:0] AOP_BR = 13'h0001, AOP_RI = 13'h0002, AOP_UJ = 13'h0003;

  localparam logic [12:0] NONE   = 13'h0000;
  localparam logic [12:0] F_WAIT = MREQ | MRD;
  localparam logic [12:0] F_OK   = MREQ | MRD | IRW;
  localparam logic [12:0] EX_R   = AOP_RI;
  localparam logic [12:0] EX_I   = ASRC | AOP_RI;
  localparam logic [12:0] EX_LUI = ASRC | AOP_UJ;
  localparam logic [12:0] EX_JAL = ASRC | JMP | AOP_UJ;
  localparam logic [12:0] EX_LS  = ASRC;
  localparam logic [12:0] EX_BR  = BRN | PCW | AOP_BR;
  localparam logic [12:0] M_LW   = MREQ | MRD;
  localparam logic [12:0] M_SW_W = MREQ | MWR;
  localparam logic [12:0] M_SW   = MREQ | MWR | PCW;
  localparam logic [12:0] WB_ALU = RGW | PCW;
  localparam logic [12:0] WB_LW  = RGW | PCW | M2R_MEM;
  localparam logic [12:0] WB_JAL = RGW | PCW | M2R_PC4;

  logic [12:0] ctl, nj_ctl;
  assign ctl = {bus.mem_req, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.ALUSrc, bus.Branch,
                bus.Jump, bus.PCWrite, bus.IRWrite, bus.MemtoReg, bus.ALUOp};
  assign nj_ctl = {nj_bus.mem_req, nj_bus.MemRead, nj_bus.MemWrite, nj_bus.RegWrite, nj_bus.ALUSrc,
                   nj_bus.Branch, nj_bus.Jump, nj_bus.PCWrite, nj_bus.IRWrite, nj_bus.MemtoReg,
                   nj_bus.ALUOp};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [12:0] ctl;
    logic        ill;
    logic        to;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic rdy, input logic [2:0] st,
                     input logic [12:0] c, input logic ill, input logic to);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.ill = ill; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 'h%0h, expected 'h%0h", name, idx, act, exp);
    end
  endtask

  logic [6:0] prog [4];
  int cyc, pcw_n, irw_n, rgw_n, k;

  initial begin
    bus.Opcode = '0;    bus.mem_ready = 1'b0;
    nj_bus.Opcode = '0; nj_bus.mem_ready = 1'b0;

    // Reset, then ADD with zero-wait memory
    add(1'b1, OP_R,   1'b1, S_F, NONE,   1'b0, 1'b0); // 0
    add(1'b0, OP_R,   1'b1, S_F, F_OK,   1'b0, 1'b0);
    add(1'b0, OP_R,   1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_R,   1'b1, S_E, EX_R,   1'b0, 1'b0);
    add(1'b0, OP_R,   1'b1, S_W, WB_ALU, 1'b0, 1'b0);
    // LW with three wait cycles in MEM
    add(1'b0, OP_LW,  1'b1, S_F, F_OK,   1'b0, 1'b0); // 5
    add(1'b0, OP_LW,  1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b1, S_E, EX_LS,  1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b1, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b1, S_W, WB_LW,  1'b0, 1'b0);
    // BEQ, SW, JAL, LUI, ADDI
    add(1'b0, OP_BR,  1'b1, S_F, F_OK,   1'b0, 1'b0); // 13
    add(1'b0, OP_BR,  1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_BR,  1'b1, S_E, EX_BR,  1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b1, S_F, F_OK,   1'b0, 1'b0); // 16
    add(1'b0, OP_SW,  1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b1, S_E, EX_LS,  1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b1, S_M, M_SW,   1'b0, 1'b0);
    add(1'b0, OP_JAL, 1'b1, S_F, F_OK,   1'b0, 1'b0); // 20
    add(1'b0, OP_JAL, 1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_JAL, 1'b1, S_E, EX_JAL, 1'b0, 1'b0);
    add(1'b0, OP_JAL, 1'b1, S_W, WB_JAL, 1'b0, 1'b0);
    add(1'b0, OP_LUI, 1'b1, S_F, F_OK,   1'b0, 1'b0); // 24
    add(1'b0, OP_LUI, 1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_LUI, 1'b1, S_E, EX_LUI, 1'b0, 1'b0);
    add(1'b0, OP_LUI, 1'b1, S_W, WB_ALU, 1'b0, 1'b0);
    add(1'b0, OP_I,   1'b1, S_F, F_OK,   1'b0, 1'b0); // 28
    add(1'b0, OP_I,   1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_I,   1'b1, S_E, EX_I,   1'b0, 1'b0);
    add(1'b0, OP_I,   1'b1, S_W, WB_ALU, 1'b0, 1'b0);
    // Fetch completes on the 4th wait cycle: no trap; then illegal opcode traps
    add(1'b0, OP_BAD, 1'b0, S_F, F_WAIT, 1'b0, 1'b0); // 32
    add(1'b0, OP_BAD, 1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_BAD, 1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_BAD, 1'b1, S_F, F_OK,   1'b0, 1'b0);
    add(1'b0, OP_BAD, 1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_BAD, 1'b1, S_T, NONE,   1'b1, 1'b0);
    add(1'b0, OP_R,   1'b1, S_T, NONE,   1'b1, 1'b0);
    // Reset out of TRAP, then fetch timeout after 4 wait cycles
    add(1'b1, OP_R,   1'b0, S_F, NONE,   1'b0, 1'b0); // 39
    add(1'b0, OP_R,   1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_R,   1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_R,   1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_R,   1'b0, S_F, F_WAIT, 1'b0, 1'b0);
    add(1'b0, OP_R,   1'b0, S_T, NONE,   1'b0, 1'b1);
    add(1'b0, OP_R,   1'b1, S_T, NONE,   1'b0, 1'b1);
    // Reset aborts a waiting SW without a MemWrite/PCWrite pulse
    add(1'b1, OP_SW,  1'b1, S_F, NONE,   1'b0, 1'b0); // 46
    add(1'b0, OP_SW,  1'b1, S_F, F_OK,   1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b1, S_E, EX_LS,  1'b0, 1'b0);
    add(1'b0, OP_SW,  1'b0, S_M, M_SW_W, 1'b0, 1'b0);
    add(1'b1, OP_SW,  1'b1, S_F, NONE,   1'b0, 1'b0);
    // LW timing out in MEM
    add(1'b0, OP_LW,  1'b1, S_F, F_OK,   1'b0, 1'b0); // 52
    add(1'b0, OP_LW,  1'b1, S_D, NONE,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b1, S_E, EX_LS,  1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b0, S_M, M_LW,   1'b0, 1'b0);
    add(1'b0, OP_LW,  1'b1, S_T, NONE,   1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      bus.Opcode    = vecs[i].op;
      bus.mem_ready = vecs[i].rdy;
      #1;
      check("state", i, 16'(bus.state), 16'(vecs[i].st));
      check("ctl",   i, 16'(ctl),       16'(vecs[i].ctl));
      check("flags", i, 16'({bus.illegal, bus.timeout}), 16'({vecs[i].ill, vecs[i].to}));
    end

    // JAL with ENABLE_JAL=0 must trap as illegal
    @(negedge clk);
    reset = 1'b1; nj_bus.Opcode = OP_JAL; nj_bus.mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("nj_fetch_ctl", 0, 16'(nj_ctl), 16'(F_OK));
    @(negedge clk);
    #1 check("nj_decode", 0, 16'(nj_bus.state), 16'(S_D));
    @(negedge clk);
    #1;
    check("nj_trap", 0, 16'(nj_bus.state), 16'(S_T));
    check("nj_illegal", 0, 16'(nj_bus.illegal), 16'd1);
    check("nj_ctl", 0, 16'(nj_ctl), 16'(NONE));

    // Back-to-back ADD, LW, SW, BEQ at zero wait: 4+5+4+3 cycles, one PCWrite/IRWrite each
    prog[0] = OP_R; prog[1] = OP_LW; prog[2] = OP_SW; prog[3] = OP_BR;
    @(negedge clk);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.Opcode = '0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; pcw_n = 0; irw_n = 0; rgw_n = 0; k = 0;
    while (pcw_n < 4 && cyc < 40) begin
      #1;
      cyc++;
      if (bus.PCWrite)  pcw_n++;
      if (bus.RegWrite) rgw_n++;
      if (bus.IRWrite) begin
        irw_n++;
        if (k < 4) bus.Opcode = prog[k];
        k++;
      end
      if (pcw_n < 4) @(negedge clk);
    end
    check("prog_pcwrite", 0, 16'(pcw_n), 16'd4);
    check("prog_cycles",  0, 16'(cyc),   16'd16);
    check("prog_irwrite", 0, 16'(irw_n), 16'd4);
    check("prog_regwrite", 0, 16'(rgw_n), 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
